// File: rtl/pe_result_sched.sv
// Serializes per-PE results into a single ready/valid stream using round-robin arbitration.
// Optional lane-overflow detection is enabled by defining PE_SCHED_OVF_EN.
module pe_lane_buf #(
  parameter int QOUT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 cap_en,
  input  logic                 in_vld,
  input  logic [QOUT_BITS-1:0] in_data,
  input  logic                 free,
  output logic                 full,
  output logic [QOUT_BITS-1:0] data
);
  // Freeing and a new capture in the same cycle count as a reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (cap_en && in_vld && (!full || free)) begin
      full <= 1'b1;
      data <= in_data;
    end else if (free) begin
      full <= 1'b0;
    end
  end
endmodule

module pe_result_sched #(
  parameter int NUM_PE    = 8,
  parameter int QOUT_BITS = 32,
  parameter int INV_BITS  = 1,
  localparam int LW       = QOUT_BITS + INV_BITS,
  localparam int ID_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          cfg_num_results,
  input  logic [NUM_PE*LW-1:0] pe_result,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [QOUT_BITS-1:0] out_data,
  output logic [ID_W-1:0]      out_pe_id,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_flag
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                        state;
  logic [15:0]                       cnt, target;
  logic [ID_W-1:0]                   ptr, gnt_idx;
  logic                              gnt_vld, start_run, run, hs, last_hs, load;
  logic [NUM_PE-1:0]                 lane_vld, buf_full, free;
  logic [NUM_PE-1:0][QOUT_BITS-1:0]  lane_data, buf_data;

  assign start_run = (state == S_IDLE) && start;
  assign run       = (state == S_RUN);
  assign hs        = out_valid && out_ready;
  assign last_hs   = run && hs && ((cnt + 16'd1) == target);
  assign load      = run && gnt_vld && (!out_valid || out_ready) && !last_hs;
  assign busy      = run;
  assign done      = (state == S_DONE);

  genvar i;
  generate
    for (i = 0; i < NUM_PE; i++) begin : g_lane
      assign lane_vld[i]  = pe_result[i*LW + LW - 1];
      assign lane_data[i] = pe_result[i*LW +: QOUT_BITS];
      pe_lane_buf #(.QOUT_BITS(QOUT_BITS)) u_buf (
        .clk(clk), .reset(reset), .clear(start_run), .cap_en(run),
        .in_vld(lane_vld[i]), .in_data(lane_data[i]), .free(free[i]),
        .full(buf_full[i]), .data(buf_data[i])
      );
    end
  endgenerate

  // First full buffer at or after the pointer, wrapping around.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_PE; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_PE) j = j - NUM_PE;
      if (!gnt_vld && buf_full[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  always_comb begin
    free = '0;
    if (load) free[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      target <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt    <= '0;
          target <= cfg_num_results;
          ptr    <= '0;
          state  <= (cfg_num_results == 16'd0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (hs) cnt <= cnt + 16'd1;
          if (last_hs) state <= S_DONE;
          if (load) ptr <= (gnt_idx == ID_W'(NUM_PE - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A word still held when the run ends is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pe_id <= '0;
    end else if (!run || last_hs) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= buf_data[gnt_idx];
      out_pe_id <= gnt_idx;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PE_SCHED_OVF_EN
  logic [NUM_PE-1:0] drop;
  assign drop = {NUM_PE{run}} & lane_vld & buf_full & ~free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ovf_flag <= 1'b0;
    else if (start_run) ovf_flag <= 1'b0;
    else if (|drop)     ovf_flag <= 1'b1;
  end
`else
  assign ovf_flag = 1'b0;
`endif
endmodule

// File: tb/tb_pe_result_sched.sv
// Scoreboard bench for pe_result_sched: expected words queued at stimulus, checked on handshake.
module tb_pe_result_sched;
  localparam int NUM_PE = 8;
  localparam int QB     = 32;
  localparam int LW     = QB + 1;
`ifdef PE_SCHED_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]    id;
    logic [QB-1:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset, start, out_ready;
  logic [15:0]          cfg_num_results;
  logic [NUM_PE*LW-1:0] pe_result;
  logic                 out_valid, busy, done, ovf_flag;
  logic [QB-1:0]        out_data;
  logic [2:0]           out_pe_id;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  pe_result_sched #(.NUM_PE(NUM_PE), .QOUT_BITS(QB), .INV_BITS(1)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_results(cfg_num_results),
    .pe_result(pe_result), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_pe_id(out_pe_id), .busy(busy), .done(done),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted word must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got id=%0d data=%h, want none", out_pe_id, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_pe_id, out_data} !== {e.id, e.data})
          $display("FAIL sb_word: got id=%0d data=%h, want id=%0d data=%h",
                   out_pe_id, out_data, e.id, e.data);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [QB-1:0] d);
    pe_result[i*LW +: LW] = {1'b1, d};
    exp_q.push_back('{id: 3'(i), data: d});
  endtask

  task automatic do_start(input logic [15:0] n);
    cfg_num_results = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({out_valid, out_data, out_pe_id, busy, done, ovf_flag} !== '0)
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d busy=%b done=%b ovf=%b, want all 0",
               out_valid, out_data, out_pe_id, busy, done, ovf_flag);
    else passed++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_lane();
    do_start(16'd1);
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    set_lane(3, 32'h0000_1234);
    step();
    pe_result = '0;
    total++; if (out_valid !== 1'b0) $display("FAIL single_early: got %b want 0", out_valid); else passed++;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_pe_id !== 3'd3)
      $display("FAIL single_latency: got v=%b d=%h id=%0d want v=1 d=1234 id=3", out_valid, out_data, out_pe_id);
    else passed++;
    step();
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL single_done: got done=%b busy=%b want 1/0", done, busy); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_all_lanes();
    do_start(16'd8);
    for (int i = 0; i < NUM_PE; i++) set_lane(i, 32'(i));
    step();
    pe_result = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_pe_id !== 3'(k))
        $display("FAIL all_order: got v=%b id=%0d want v=1 id=%0d", out_valid, out_pe_id, k);
      else passed++;
    end
    step();
    total++; if (done !== 1'b1) $display("FAIL all_done: got %b want 1", done); else passed++;
    step();
  endtask

  task automatic test_backpressure();
    do_start(16'd1);
    out_ready = 1'b0;
    set_lane(5, 32'h77);
    step();
    pe_result = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h77 || out_pe_id !== 3'd5 || done !== 1'b0)
        $display("FAIL bp_hold: got v=%b d=%h id=%0d done=%b want v=1 d=77 id=5 done=0",
                 out_valid, out_data, out_pe_id, done);
      else passed++;
    end
    out_ready = 1'b1;
    step();
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: got done=%b v=%b want 1/0", done, out_valid);
    else passed++;
    step();
  endtask

  task automatic test_overflow();
    do_start(16'd3);
    out_ready = 1'b0;
    set_lane(0, 32'h5);
    step();
    pe_result = '0;
    step();
    set_lane(2, 32'hA);
    step();
    pe_result[2*LW +: LW] = {1'b1, 32'hB};   // lands on a full, unfreed buffer
    step();
    pe_result = '0;
    total++; if (ovf_flag !== OVF_EXP) $display("FAIL ovf_flag: got %b want %b", ovf_flag, OVF_EXP); else passed++;
    total++;
    if (out_data !== 32'h5 || out_pe_id !== 3'd0)
      $display("FAIL ovf_head: got d=%h id=%0d want d=5 id=0", out_data, out_pe_id);
    else passed++;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA || out_pe_id !== 3'd2)
      $display("FAIL ovf_kept: got v=%b d=%h id=%0d want v=1 d=a id=2", out_valid, out_data, out_pe_id);
    else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL ovf_lost: got v=%b want 0", out_valid); else passed++;
    set_lane(1, 32'hC);
    step();
    pe_result = '0;
    step();
    step();
    total++;
    if (done !== 1'b1 || ovf_flag !== OVF_EXP)
      $display("FAIL ovf_sticky: got done=%b ovf=%b want 1/%b", done, ovf_flag, OVF_EXP);
    else passed++;
    step();
  endtask

  task automatic test_zero_target();
    do_start(16'd0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || ovf_flag !== 1'b0)
      $display("FAIL zero_done: got done=%b busy=%b v=%b ovf=%b want 1/0/0/0", done, busy, out_valid, ovf_flag);
    else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL zero_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    do_start(16'd8);
    for (int i = 0; i < NUM_PE; i++) pe_result[i*LW +: LW] = {1'b1, 32'(32'h10 + i)};
    for (int i = 0; i < 3; i++) exp_q.push_back('{id: 3'(i), data: 32'(32'h10 + i)});
    step();
    pe_result = '0;
    step(); step(); step();
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, out_pe_id, busy, done} !== '0)
      $display("FAIL rst_mid_outputs: got v=%b d=%h id=%0d busy=%b done=%b want all 0",
               out_valid, out_data, out_pe_id, busy, done);
    else passed++;
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL rst_mid_nodone: got %b want 0", saw_done); else passed++;
  endtask

  task automatic test_back_to_back();
    do_start(16'd2);
    set_lane(6, 32'hAA);
    set_lane(7, 32'hBB);
    step();
    pe_result = '0;
    cfg_num_results = 16'd0;
    start = 1'b1;                              // must be ignored while running
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || out_pe_id !== 3'd6)
      $display("FAIL b2b_first: got busy=%b id=%0d want 1/6", busy, out_pe_id);
    else passed++;
    step();
    total++; if (out_pe_id !== 3'd7 || out_valid !== 1'b1) $display("FAIL b2b_second: got id=%0d v=%b want 7/1", out_pe_id, out_valid); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else passed++;
    step();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    cfg_num_results = '0;
    pe_result = '0;
    out_ready = 1'b1;
    step(); step();
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_backpressure();
    test_overflow();
    test_zero_target();
    test_reset_mid_run();
    test_back_to_back();
    step();
    total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
